// File: rtl/core_mem_responder.sv
// core_mem_responder
// Memory-side target for the core's stage sequencer. Accepts one load/store
// at a time, performs it against a word-addressed byte-strobed memory after a
// fixed latency, and holds the response until the initiator takes it.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_we, req_addr, req_wdata,  request payload (store when req_we = 1;
//   req_wstrb                     strobes ignored on loads)
//   resp_valid / resp_ready       response handshake
//   resp_rdata, resp_err          load data (0 on store/error), addr >= DEPTH
module core_mem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acc_fire_c;
    logic              acc_err_c;
    logic [IDX_W-1:0]  acc_idx_c;
    logic [DATA_W-1:0] rd_word_c;

    // Address decode for the latched request; the read is guarded by range.
    always_comb begin
        acc_err_c = (32'(addr_q) >= DEPTH);
        acc_idx_c = IDX_W'(addr_q);
        rd_word_c = '0;
        if (!acc_err_c) begin
            rd_word_c = mem_q[acc_idx_c];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        acc_fire_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    // WAIT is entered even for LATENCY == 1 (counter already 0)
                    // so resp_valid always rises LATENCY edges after acceptance.
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_fire_c = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (acc_fire_c) begin
            rdata_d = (we_q || acc_err_c) ? '0 : rd_word_c;
            err_d   = acc_err_c;
        end

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Byte-strobed store, committed on the edge that enters RESP; not reset.
    always_ff @(posedge clk) begin
        if (acc_fire_c && we_q && !acc_err_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb_q[i]) begin
                    mem_q[acc_idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: three instances (LATENCY 2, 1, 3; DEPTH 1000)
// driven by directed and random transactions, checked against an array model.
module tb_core_mem_responder;

    localparam int unsigned NI    = 3;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned DEPTH = 1000;

    logic clk;
    logic [NI-1:0]         rst, req_valid, req_ready, req_we;
    logic [NI-1:0]         resp_valid, resp_ready, resp_err;
    logic [NI-1:0][AW-1:0] req_addr;
    logic [NI-1:0][DW-1:0] req_wdata, resp_rdata;
    logic [NI-1:0][SW-1:0] req_wstrb;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [DW-1:0] model [NI][DEPTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        core_mem_responder #(
            .ADDR_W (AW),
            .DEPTH  (DEPTH),
            .DATA_W (DW),
            .LATENCY((g == 1) ? 1 : ((g == 2) ? 3 : 2))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wstrb (req_wstrb[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 1) ? 1 : ((g == 2) ? 3 : 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_reset_outputs(input int g, input string tag);
        check({tag, "_req_ready"},  32'(req_ready[g]),  32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid[g]), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata[g],      32'd0);
        check({tag, "_resp_err"},   32'(resp_err[g]),   32'd0);
    endtask

    // One complete transaction; expectation comes from the array model.
    task automatic txn(input int g, input bit we, input int addr, input logic [31:0] wd,
                       input logic [3:0] ws, input int hold, output int acc_cyc);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        exp_err = (addr >= int'(DEPTH));
        exp_rd  = 32'd0;
        if (!exp_err && !we) exp_rd = model[g][addr];
        if (!exp_err && we) begin
            for (int i = 0; i < 4; i++)
                if (ws[i]) model[g][addr][8*i +: 8] = wd[8*i +: 8];
        end

        check("req_ready_idle", 32'(req_ready[g]), 32'd1);
        req_valid[g]  = 1'b1;
        req_we[g]     = we;
        req_addr[g]   = AW'(addr);
        req_wdata[g]  = wd;
        req_wstrb[g]  = ws;
        resp_ready[g] = (hold == 0);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        // Scramble the request bus: it must be ignored after acceptance.
        req_valid[g] = 1'b0;
        req_we[g]    = 1'($urandom);
        req_addr[g]  = AW'($urandom);
        req_wdata[g] = $urandom;
        req_wstrb[g] = SW'($urandom);

        n = 0;
        while (resp_valid[g] !== 1'b1 && n < 20) begin
            check("req_ready_busy", 32'(req_ready[g]), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check("latency",    32'(n),            32'(lat_of(g)));
        check("resp_rdata", resp_rdata[g],     exp_rd);
        check("resp_err",   32'(resp_err[g]),  32'(exp_err));
        check("req_ready_resp", 32'(req_ready[g]), 32'd0);

        repeat (hold) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(resp_valid[g]), 32'd1);
            check("bp_rdata", resp_rdata[g],      exp_rd);
            check("bp_err",   32'(resp_err[g]),   32'(exp_err));
            check("bp_ready", 32'(req_ready[g]),  32'd0);
        end

        resp_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        check("resp_done",       32'(resp_valid[g]), 32'd0);
        check("req_ready_after", 32'(req_ready[g]),  32'd1);
        resp_ready[g] = 1'b0;
    endtask

    initial begin
        int a0, a1, n;
        rst        = '1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wstrb  = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < int'(NI); g++) check_reset_outputs(g, "rst_init");
        rst = '0;

        // Full store then load (LATENCY 2).
        txn(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, 0, a0);
        txn(0, 1'b0, 5, 32'h0, 4'h0, 0, a0);
        // Partial store, then load shows merged bytes.
        txn(0, 1'b1, 5, 32'h000000AA, 4'h1, 0, a0);
        txn(0, 1'b0, 5, 32'h0, 4'h0, 0, a0);
        // Backpressure on a load for 5 cycles.
        txn(0, 1'b0, 5, 32'h0, 4'h0, 5, a0);
        // Store with no strobes leaves memory unchanged.
        txn(0, 1'b1, 5, 32'h55555555, 4'h0, 0, a0);
        txn(0, 1'b0, 5, 32'h0, 4'h0, 1, a0);
        // Out-of-range store and load.
        txn(0, 1'b1, 1000, 32'h12345678, 4'hF, 0, a0);
        txn(0, 1'b0, 1000, 32'h0, 4'h0, 0, a0);
        txn(0, 1'b0, 1023, 32'h0, 4'h0, 2, a0);

        // Reset while in RESP: committed store survives.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = AW'(9);
        req_wdata[0] = 32'hCAFEF00D;
        req_wstrb[0] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        model[0][9]  = 32'hCAFEF00D;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("resp_wait_before_rst", 32'(resp_valid[0]), 32'd1);
        rst[0] = 1'b1;
        #1;
        check_reset_outputs(0, "rst_in_resp");
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        txn(0, 1'b0, 9, 32'h0, 4'h0, 0, a0);

        // LATENCY 1: latency and back-to-back acceptance spacing.
        txn(1, 1'b1, 3, 32'hA5A5A5A5, 4'hF, 0, a0);
        txn(1, 1'b0, 3, 32'h0, 4'h0, 0, a1);
        // Accept at k, resp rises at k+1, handshake at k+2, next accept at k+3.
        check("b2b_spacing", 32'(a1 - a0), 32'd3);

        // LATENCY 3: reset one cycle after a store is accepted aborts it.
        txn(2, 1'b1, 7, 32'h11111111, 4'hF, 0, a0);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = AW'(7);
        req_wdata[2] = 32'h22222222;
        req_wstrb[2] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        #1;
        check_reset_outputs(2, "rst_in_wait");
        repeat (3) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        txn(2, 1'b0, 7, 32'h0, 4'h0, 0, a0);

        // Random traffic on every instance against the model.
        for (int g = 0; g < int'(NI); g++) begin
            for (int a = 0; a < 16; a++) txn(g, 1'b1, a, $urandom, 4'hF, 0, a0);
            for (int t = 0; t < 25; t++) begin
                int addr;
                addr = (($urandom % 8) == 0) ? (998 + int'($urandom % 4)) : int'($urandom % 16);
                txn(g, 1'($urandom), addr, $urandom, SW'($urandom), int'($urandom % 4), a0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
